// File: rtl/calculator_sequencer.sv
// Operand/operation sequencer for the calculator.
// Captures A/B from switches, computes C; multiply is shift-add.
module calculator_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] sw,
  input  logic [1:0]  op_sel,
  input  logic        enter,
  input  logic        clear,
  output logic [15:0] A,
  output logic [15:0] B,
  output logic [15:0] C,
  output logic        flag,
  output logic        busy,
  output logic [2:0]  state_out
);

  typedef enum logic [2:0] {
    S_LOAD_A  = 3'd0,
    S_LOAD_B  = 3'd1,
    S_OP_SEL  = 3'd2,
    S_COMPUTE = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  state_e      state_q;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [15:0] c_q;
  logic        flag_q;
  logic        busy_q;
  logic [1:0]  op_q;
  logic [3:0]  cnt_q;
  logic [31:0] acc_q;
  logic [31:0] mcand_q;
  logic [15:0] mplier_q;

  logic [31:0] acc_d;
  logic [16:0] sum_d;
  logic [15:0] res_c_d;
  logic        res_f_d;

  always_comb begin
    acc_d = acc_q + (mplier_q[0] ? mcand_q : 32'd0);
    sum_d = {1'b0, a_q} + {1'b0, b_q};
  end

  always_comb begin
    res_c_d = '0;
    res_f_d = 1'b0;
    case (op_q)
      OP_ADD: begin
        res_c_d = sum_d[15:0];
        res_f_d = sum_d[16];
      end
      OP_SUB: begin
        res_c_d = a_q - b_q;
        res_f_d = (a_q < b_q);
      end
      OP_AND: res_c_d = a_q & b_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q  <= S_LOAD_A;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      flag_q   <= 1'b0;
      busy_q   <= 1'b0;
      op_q     <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      case (state_q)
        S_LOAD_A: if (enter) begin
          a_q     <= sw;
          state_q <= S_LOAD_B;
        end
        S_LOAD_B: if (enter) begin
          b_q     <= sw;
          state_q <= S_OP_SEL;
        end
        S_OP_SEL: if (enter) begin
          op_q     <= op_sel;
          flag_q   <= 1'b0;
          cnt_q    <= '0;
          acc_q    <= '0;
          mcand_q  <= {16'd0, a_q};
          mplier_q <= b_q;
          busy_q   <= 1'b1;
          state_q  <= S_COMPUTE;
        end
        S_COMPUTE: begin
          if (op_q == OP_MUL) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 4'd1;
            // Last bit of B: commit the final accumulator
            if (cnt_q == 4'd15) begin
              c_q     <= acc_d[15:0];
              flag_q  <= |acc_d[31:16];
              busy_q  <= 1'b0;
              state_q <= S_DONE;
            end
          end else begin
            c_q     <= res_c_d;
            flag_q  <= res_f_d;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end
        end
        S_DONE: if (enter) begin
          a_q     <= c_q;
          b_q     <= '0;
          flag_q  <= 1'b0;
          state_q <= S_LOAD_B;
        end
        default: state_q <= S_LOAD_A;
      endcase
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign C         = c_q;
  assign flag      = flag_q;
  assign busy      = busy_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_calculator_sequencer.sv
// Bench for calculator_sequencer: cycle model plus directed vectors.
// Model computes results arithmetically with a latency countdown.
module tb_calculator_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] sw = '0;
  logic [1:0]  op_sel = '0;
  logic        enter = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] A, B, C;
  logic        flag, busy;
  logic [2:0]  state_out;

  int nvec = 0;
  int nerr = 0;
  bit armed = 1'b0;

  calculator_sequencer dut (
    .clk(clk), .reset(reset), .sw(sw), .op_sel(op_sel),
    .enter(enter), .clear(clear), .A(A), .B(B), .C(C),
    .flag(flag), .busy(busy), .state_out(state_out)
  );

  always #5 clk = ~clk;

  // Model state
  int          m_st;
  logic [15:0] m_a, m_b, m_c;
  logic        m_flag, m_busy;
  logic [1:0]  m_op;
  int          m_left;

  function automatic logic [16:0] result(
    input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    case (op)
      2'b00: result = {1'b0, a} + {1'b0, b};
      2'b01: result = {(a < b), a - b};
      2'b10: begin
        p = a * b;
        result = {(p[31:16] != 0), p[15:0]};
      end
      default: result = {1'b0, a & b};
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset || clear) begin
      m_st <= 0; m_a <= 0; m_b <= 0; m_c <= 0;
      m_flag <= 0; m_busy <= 0; m_op <= 0; m_left <= 0;
    end else begin
      case (m_st)
        0: if (enter) begin m_a <= sw; m_st <= 1; end
        1: if (enter) begin m_b <= sw; m_st <= 2; end
        2: if (enter) begin
          m_op <= op_sel; m_flag <= 0; m_busy <= 1; m_st <= 3;
          m_left <= (op_sel == 2'b10) ? 16 : 1;
        end
        3: begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            {m_flag, m_c} <= result(m_op, m_a, m_b);
            m_busy <= 0; m_st <= 4;
          end
        end
        4: if (enter) begin
          m_a <= m_c; m_b <= 0; m_flag <= 0; m_st <= 1;
        end
        default: m_st <= 0;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      chk("m_state", {29'd0, state_out}, m_st);
      chk("m_A", {16'd0, A}, {16'd0, m_a});
      chk("m_B", {16'd0, B}, {16'd0, m_b});
      chk("m_C", {16'd0, C}, {16'd0, m_c});
      chk("m_flag", {31'd0, flag}, {31'd0, m_flag});
      chk("m_busy", {31'd0, busy}, {31'd0, m_busy});
    end
  end

  // All tasks start and end just after a falling edge
  task automatic press(input logic [15:0] s, input logic [1:0] o);
    sw = s; op_sel = o; enter = 1'b1;
    @(negedge clk);
    enter = 1'b0; sw = $urandom; op_sel = 2'($urandom);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic res(input string nm, input logic [15:0] c,
                     input logic f);
    chk({nm, "_state"}, {29'd0, state_out}, 32'd4);
    chk({nm, "_C"}, {16'd0, C}, {16'd0, c});
    chk({nm, "_flag"}, {31'd0, flag}, {31'd0, f});
    chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    sw = 16'hFFFF;
    tick(2);
    armed = 1'b1;
    reset = 1'b0;
    chk("rst_state", {29'd0, state_out}, 32'd0);
    chk("rst_A", {16'd0, A}, 32'd0);
    chk("rst_C", {16'd0, C}, 32'd0);
    tick(3);
    chk("idle_A", {16'd0, A}, 32'd0);

    // Add with carry out
    press(16'hFFFF, 2'b00);
    chk("ldA", {16'd0, A}, 32'h0000FFFF);
    chk("ldA_state", {29'd0, state_out}, 32'd1);
    press(16'h0001, 2'b00);
    press(16'h0000, 2'b00);
    chk("add_busy", {31'd0, busy}, 32'd1);
    chk("add_st", {29'd0, state_out}, 32'd3);
    tick(1);
    res("add", 16'h0000, 1'b1);

    // Subtract with and without borrow
    do_clear();
    press(16'h0003, 2'b00);
    press(16'h0005, 2'b00);
    press(16'h0000, 2'b01);
    tick(1);
    res("sub_b", 16'hFFFE, 1'b1);
    do_clear();
    press(16'h0005, 2'b00);
    press(16'h0003, 2'b00);
    press(16'h0000, 2'b01);
    tick(1);
    res("sub", 16'h0002, 1'b0);

    // Multiply, 16 busy cycles
    do_clear();
    press(16'h00FF, 2'b00);
    press(16'h0101, 2'b00);
    chk("mul_pre_busy", {31'd0, busy}, 32'd0);
    press(16'h0000, 2'b10);
    for (int i = 0; i < 16; i++) begin
      chk("mul_busy", {31'd0, busy}, 32'd1);
      chk("mul_C_hold", {16'd0, C}, 32'd0);
      tick(1);
    end
    res("mul", 16'hFFFF, 1'b0);
    do_clear();
    press(16'h0100, 2'b00);
    press(16'h0100, 2'b00);
    press(16'h0000, 2'b10);
    tick(16);
    res("mul_ovf", 16'h0000, 1'b1);

    // Clear on 8th compute cycle with enter
    do_clear();
    press(16'h1234, 2'b00);
    press(16'h5678, 2'b00);
    press(16'h0000, 2'b10);
    tick(7);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    clear = 1'b1; enter = 1'b1;
    @(negedge clk);
    clear = 1'b0; enter = 1'b0;
    chk("clr_state", {29'd0, state_out}, 32'd0);
    chk("clr_A", {16'd0, A}, 32'd0);
    chk("clr_B", {16'd0, B}, 32'd0);
    chk("clr_C", {16'd0, C}, 32'd0);
    chk("clr_busy", {31'd0, busy}, 32'd0);

    // Chaining 2+3 then AND 4
    press(16'h0002, 2'b00);
    press(16'h0003, 2'b00);
    press(16'h0000, 2'b00);
    tick(1);
    res("ch_add", 16'h0005, 1'b0);
    press(16'hAAAA, 2'b00);
    chk("ch_A", {16'd0, A}, 32'h5);
    chk("ch_B", {16'd0, B}, 32'h0);
    chk("ch_state", {29'd0, state_out}, 32'd1);
    chk("ch_C", {16'd0, C}, 32'h5);
    press(16'h0004, 2'b00);
    press(16'h0000, 2'b11);
    tick(1);
    res("ch_and", 16'h0004, 1'b0);

    // Held enter: each cycle is a press
    do_clear();
    sw = 16'h0007; enter = 1'b1;
    tick(2);
    enter = 1'b0;
    chk("hold_A", {16'd0, A}, 32'h7);
    chk("hold_B", {16'd0, B}, 32'h7);
    chk("hold_st", {29'd0, state_out}, 32'd2);

    // Reset mid-sequence
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("rst2_A", {16'd0, A}, 32'd0);
    chk("rst2_st", {29'd0, state_out}, 32'd0);
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/calculator_sequencer.md
# calculator_sequencer

Control and datapath sequencer for the simple calculator. It captures operands A and B from the switches on operator button presses, latches an operation, and computes result C. Add, subtract and AND complete in one cycle; multiply is an iterative 16-cycle shift-add. It drives the A, B, C and flag inputs of `calculator_output`, which renders them on VGA and turns the background red while `flag` is high.

## Interface
- No parameters; data width fixed at 16 bits.
- `clk`  in  1  system clock; same clock as `calculator_output`.
- `reset`  in  1  synchronous, active-high reset.
- `sw`  in  16  operand switches, sampled on `enter`.
- `op_sel`  in  2  operation code, sampled on `enter` in OP_SEL: 00 add, 01 subtract, 10 multiply, 11 AND.
- `enter`  in  1  single-cycle debounced pulse; advances the sequence.
- `clear`  in  1  single-cycle debounced pulse; returns to LOAD_A and zeroes everything.
- `A`, `B`, `C`  out  16 each  operand and result registers.
- `flag`  out  1  overflow or borrow indicator for the last result.
- `busy`  out  1  high while in COMPUTE.
- `state_out`  out  3  current state encoding, for LEDs and debug.

## Operation
- States and encodings: LOAD_A = 0, LOAD_B = 1, OP_SEL = 2, COMPUTE = 3, DONE = 4. Encodings 5–7 are illegal and go to LOAD_A on the next clock.
- Reset: state LOAD_A; A, B, C, `flag`, `busy`, the internal op register and the iteration counter are all 0.
- Transitions on `enter`:
  - LOAD_A: A <= `sw`, go to LOAD_B.
  - LOAD_B: B <= `sw`, go to OP_SEL.
  - OP_SEL: op <= `op_sel`, `flag` <= 0, counter <= 0, go to COMPUTE.
  - COMPUTE: `enter` is ignored.
  - DONE: chain the result. A <= C, B <= 0, `flag` <= 0, go to LOAD_B. C holds its value.
- `clear` in any state, including mid-multiply: go to LOAD_A and zero A, B, C, `flag` and the counter. `clear` has priority over `enter` in the same cycle.
- Arithmetic is unsigned. C and `flag` are written only on the cycle that enters DONE; during COMPUTE, C keeps its previous value.
  - Add: C = (A+B)[15:0]; `flag` = carry out of bit 15.
  - Subtract: C = (A−B) mod 2^16; `flag` = (A < B).
  - AND: C = A & B; `flag` = 0.
  - Multiply: LSB-first shift-add over a 32-bit accumulator, one bit of B per cycle, counter 0..15. C = product[15:0]; `flag` = (product[31:16] != 0).
- A and B are not modified during COMPUTE. The multiplier works on internal copies.
- `sw` and `op_sel` are ignored except on an accepted `enter`.

## Timing
- All outputs are registered and update on the rising edge of `clk`; there are no combinational paths from inputs to outputs.
- LOAD_A and LOAD_B: an `enter` at edge t makes A or B valid after edge t, and the new state is visible in the same cycle.
- `enter` in OP_SEL at edge t: state = COMPUTE and `busy` = 1 from t+1.
  - Add, subtract, AND: state = DONE, `busy` = 0, C and `flag` valid from t+2.
  - Multiply: 16 cycles in COMPUTE; DONE, C and `flag` valid from t+17.
- `clear` at edge t: every register is zero and state = LOAD_A from t+1, regardless of the state before.
- `reset` behaves identically to `clear` and has priority over both `clear` and `enter`.
- `enter` held high for several cycles is not rejected: each high cycle is a separate press. Debouncing and single-pulsing are upstream responsibilities.

## Test plan
- Reset then idle: after `reset`, A = B = C = 0, `flag` = 0, `busy` = 0, `state_out` = 0; holding `sw` = 0xFFFF with no `enter` leaves A = 0.
- Add overflow: A = 0xFFFF, B = 0x0001, op 00 -> C = 0x0000 and `flag` = 1 exactly two cycles after the op `enter`.
- Subtract borrow: A = 0x0003, B = 0x0005, op 01 -> C = 0xFFFE, `flag` = 1. Then A = 0x0005, B = 0x0003 -> C = 0x0002, `flag` = 0.
- Multiply: 0x00FF × 0x0101 -> C = 0xFFFF, `flag` = 0 with DONE at t+17 and `busy` high for exactly 16 cycles. Then 0x0100 × 0x0100 -> C = 0x0000, `flag` = 1.
- Clear mid-multiply: `clear` on the 8th COMPUTE cycle -> next cycle state = LOAD_A and A = B = C = 0. A simultaneous `enter` has no effect.
- Chaining: after 2 + 3 = 5, `enter` in DONE -> A = 0x0005, B = 0, state = LOAD_B, C = 0x0005. Then B = 0x0004 with op AND -> C = 0x0004.
